// File: rtl/gauss_window_master.sv
// Hardware master that slides a 3x3 window over every interior pixel, feeds it
// to the Gaussian peripheral, polls for completion and stores the filtered pixel.
module gauss_window_master #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int ADDR_W   = 16,
    parameter int POLL_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              res_we_o,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic [7:0]        res_data_o,
    output logic              g_select_o,
    output logic              g_we_o,
    output logic [31:0]       g_entrada_o,
    input  logic [31:0]       g_salida_i
);

    localparam int CXW = $clog2(IMG_W + 1);
    localparam int CYW = $clog2(IMG_H + 1);
    localparam int PW  = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_KICK, S_POLL, S_READ, S_STORE, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CXW-1:0]    r_cx;
    logic [CYW-1:0]    r_cy;
    logic [3:0]        r_k;
    logic [1:0]        r_dx;
    logic [1:0]        r_dy;
    logic [PW-1:0]     r_poll;
    logic              r_error;
    logic [ADDR_W-1:0] r_res_addr;
    logic [7:0]        r_res_data;

    logic              w_last_cx;
    logic              w_last_cy;
    logic              w_poll_done;
    logic              w_poll_timeout;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [ADDR_W-1:0] w_centre_addr;
    logic              w_unused;

    assign w_last_cx      = (r_cx == CXW'(IMG_W - 2));
    assign w_last_cy      = (r_cy == CYW'(IMG_H - 2));
    // The first poll cycle is skipped: the peripheral's busy bit is not yet valid.
    assign w_poll_done    = (r_poll != '0) && !g_salida_i[0];
    assign w_poll_timeout = (r_poll == PW'(POLL_MAX - 1));

    assign w_fetch_addr  = (ADDR_W'(r_cy) + ADDR_W'(r_dy) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                         + ADDR_W'(r_cx) + ADDR_W'(r_dx) - ADDR_W'(1);
    assign w_centre_addr = ADDR_W'(r_cy) * ADDR_W'(IMG_W) + ADDR_W'(r_cx);

    assign w_unused   = ^g_salida_i[31:8];
    assign error_o    = r_error;
    assign res_addr_o = r_res_addr;
    assign res_data_o = r_res_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cx       <= '0;
            r_cy       <= '0;
            r_k        <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_poll     <= '0;
            r_error    <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_error <= 1'b0;
                        r_cx    <= CXW'(1);
                        r_cy    <= CYW'(1);
                        r_k     <= '0;
                        r_dx    <= '0;
                        r_dy    <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_k == 4'd9) begin
                        r_k  <= '0;
                        r_dx <= '0;
                        r_dy <= '0;
                    end else begin
                        r_k <= r_k + 4'd1;
                        if (r_dx == 2'd2) begin
                            r_dx <= '0;
                            r_dy <= r_dy + 2'd1;
                        end else begin
                            r_dx <= r_dx + 2'd1;
                        end
                    end
                end
                S_KICK: r_poll <= '0;
                S_POLL: begin
                    r_poll <= r_poll + PW'(1);
                    if (!w_poll_done && w_poll_timeout) r_error <= 1'b1;
                end
                S_READ: begin
                    r_res_data <= g_salida_i[7:0];
                    r_res_addr <= w_centre_addr;
                end
                S_STORE: begin
                    if (w_last_cx) begin
                        r_cx <= CXW'(1);
                        if (!w_last_cy) r_cy <= r_cy + CYW'(1);
                    end else begin
                        r_cx <= r_cx + CXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_addr_o  = '0;
        res_we_o    = 1'b0;
        g_select_o  = 1'b0;
        g_we_o      = 1'b0;
        g_entrada_o = '0;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_FETCH;
            S_FETCH: begin
                busy_o = 1'b1;
                // Address for byte k goes out on cycle k; its data is written on cycle k+1.
                if (r_k != 4'd9) mem_addr_o = w_fetch_addr;
                if (r_k != 4'd0) begin
                    g_select_o  = 1'b1;
                    g_we_o      = 1'b1;
                    g_entrada_o = {24'b0, mem_rdata_i};
                end
                if (r_k == 4'd9) w_next = S_KICK;
            end
            S_KICK: begin
                busy_o      = 1'b1;
                g_we_o      = 1'b1;
                g_entrada_o = 32'h1;
                w_next      = S_POLL;
            end
            S_POLL: begin
                busy_o = 1'b1;
                if (w_poll_done)         w_next = S_READ;
                else if (w_poll_timeout) w_next = S_ERR;
            end
            S_READ: begin
                busy_o     = 1'b1;
                g_select_o = 1'b1;
                w_next     = S_STORE;
            end
            S_STORE: begin
                busy_o   = 1'b1;
                res_we_o = 1'b1;
                w_next   = (w_last_cx && w_last_cy) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gauss_window_master.sv
// Directed-sequence bench with random images and random peripheral latency,
// checked against a scoreboard computed straight from the image array.
module tb_gauss_window_master;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int AW   = 16;
    localparam int PM   = 8;
    localparam int NWIN = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, error_o, res_we_o, g_select_o, g_we_o;
    logic [AW-1:0] mem_addr_o, res_addr_o;
    logic [7:0]    mem_rdata_i = 8'h0;
    logic [7:0]    res_data_o;
    logic [31:0]   g_entrada_o, g_salida_i;

    gauss_window_master #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .res_we_o(res_we_o), .res_addr_o(res_addr_o), .res_data_o(res_data_o),
        .g_select_o(g_select_o), .g_we_o(g_we_o), .g_entrada_o(g_entrada_o),
        .g_salida_i(g_salida_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pixel memory with one-cycle synchronous read.
    logic [7:0] img [W*H];
    always @(posedge clk) mem_rdata_i <= img[mem_addr_o];

    // Peripheral model: collects nine bytes, filters on the control write,
    // and reports busy for a randomly chosen number of cycles.
    int         lat [64];
    int         pd [9];
    int         pwr = 0;
    int         pcnt = 0;
    int         nk = 0;
    logic [7:0] pres = 8'h0;
    bit         p_stuck = 1'b0;

    function automatic logic [7:0] gk(input int p[9]);
        int wt[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        for (int i = 0; i < 9; i++) s += wt[i] * p[i];
        return 8'(s / 16);
    endfunction

    always @(posedge clk) begin
        if (pcnt > 0) pcnt <= pcnt - 1;
        if (g_we_o && g_select_o) begin
            pd[pwr % 9] <= int'(g_entrada_o[7:0]);
            pwr <= pwr + 1;
        end else if (g_we_o && g_entrada_o == 32'h1) begin
            pres <= gk(pd);
            pcnt <= lat[nk % 64];
            nk   <= nk + 1;
            pwr  <= 0;
        end
    end

    assign g_salida_i = g_select_o ? {24'b0, pres} : {31'b0, (p_stuck || pcnt > 0)};

    // Event recorder
    typedef struct { int cyc; logic sel; logic [31:0] d; } gw_t;
    typedef struct { int cyc; logic [AW-1:0] a; logic [7:0] d; } rw_t;
    gw_t q_gw[$];
    rw_t q_res[$];
    int  n_done = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (g_we_o)   q_gw.push_back('{cyc, g_select_o, g_entrada_o});
            if (res_we_o) q_res.push_back('{cyc, res_addr_o, res_data_o});
            if (done_o)   n_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_win(input int cx, input int cy);
        int s = 0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                s += int'(img[(cy - 1 + dy) * W + cx - 1 + dx]) * (dx == 1 ? 2 : 1) * (dy == 1 ? 2 : 1);
        return s / 16;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, busy_o, 0);
        check({pfx, "_done"}, done_o, 0);
        check({pfx, "_error"}, error_o, 0);
        check({pfx, "_res_we"}, res_we_o, 0);
        check({pfx, "_g_we"}, g_we_o, 0);
        check({pfx, "_g_sel"}, g_select_o, 0);
        check({pfx, "_mem_addr"}, mem_addr_o, 0);
        check({pfx, "_res_addr"}, res_addr_o, 0);
        check({pfx, "_res_data"}, res_data_o, 0);
        check({pfx, "_entrada"}, g_entrada_o, 0);
    endtask

    task automatic fill_image();
        for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
    endtask

    // Leaves the caller at the negedge of the first FETCH cycle.
    task automatic start_pass(output int c0, output int k0, output int b_gw,
                              output int b_res, output int b_done);
        @(negedge clk);
        b_gw = q_gw.size(); b_res = q_res.size(); b_done = n_done;
        c0 = cyc; k0 = nk;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done_o) break;
            @(negedge clk);
        end
        check("done_seen", done_o, 1);
    endtask

    task automatic check_pass(input int c0, input int k0, input int b_gw,
                              input int b_res, input int b_done);
        int f;
        int p;
        f = c0 + 1;
        check("res_count", q_res.size() - b_res, NWIN);
        check("g_we_count", q_gw.size() - b_gw, 10 * NWIN);
        check("done_count", n_done - b_done, 1);
        check("error_low", error_o, 0);
        for (int i = 0; i < NWIN; i++) begin
            int cx = 1 + i % (W - 2);
            int cy = 1 + i / (W - 2);
            if (b_res + i < q_res.size()) begin
                p = (lat[(k0 + i) % 64] < 1 ? 1 : lat[(k0 + i) % 64]) + 1;
                check("res_addr", q_res[b_res + i].a, cy * W + cx);
                check("res_data", q_res[b_res + i].d, exp_win(cx, cy));
                check("res_cycle", q_res[b_res + i].cyc, f + 12 + p);
                f = q_res[b_res + i].cyc + 1;
            end
            for (int j = 0; j < 10; j++) begin
                if (b_gw + 10 * i + j < q_gw.size()) begin
                    gw_t e = q_gw[b_gw + 10 * i + j];
                    if (j < 9) begin
                        check("gw_data_sel", e.sel, 1);
                        check("gw_data", e.d, {24'b0, img[(cy - 1 + j / 3) * W + cx - 1 + j % 3]});
                    end else begin
                        check("gw_ctrl_sel", e.sel, 0);
                        check("gw_ctrl", e.d, 32'h1);
                    end
                end
            end
        end
    endtask

    initial begin
        int c0, k0, b_gw, b_res, b_done, kick, errc;
        for (int i = 0; i < 64; i++) lat[i] = $urandom_range(0, 5);
        fill_image();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Pass 1: cycle trace of the first window, stray starts, full scoreboard.
        start_pass(c0, k0, b_gw, b_res, b_done);
        check("busy_after_start", busy_o, 1);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 9) check("trace_addr", mem_addr_o, (k / 3) * W + k % 3);
            if (k == 0) begin
                check("trace_we0", g_we_o, 0);
            end else if (k < 10) begin
                check("trace_we", g_we_o, 1);
                check("trace_sel", g_select_o, 1);
                check("trace_data", g_entrada_o, {24'b0, img[((k - 1) / 3) * W + (k - 1) % 3]});
            end else begin
                check("trace_kick_we", g_we_o, 1);
                check("trace_kick_sel", g_select_o, 0);
                check("trace_kick_data", g_entrada_o, 32'h1);
            end
        end
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_done(2000);
        start_i = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", busy_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        check("still_idle", busy_o, 0);
        check_pass(c0, k0, b_gw, b_res, b_done);

        // Pass 2: peripheral never finishes.
        p_stuck = 1'b1;
        fill_image();
        start_pass(c0, k0, b_gw, b_res, b_done);
        for (int i = 0; i < 200; i++) begin
            if (error_o) break;
            @(negedge clk);
        end
        errc = cyc;
        check("timeout_error", error_o, 1);
        check("timeout_busy", busy_o, 0);
        kick = -1;
        for (int i = b_gw; i < q_gw.size(); i++) if (!q_gw[i].sel) kick = q_gw[i].cyc;
        check("timeout_poll_cycles", errc - kick, 9);
        check("timeout_g_we_count", q_gw.size() - b_gw, 10);
        repeat (2) begin
            @(negedge clk);
            check("timeout_no_done", done_o, 0);
            check("timeout_sticky", error_o, 1);
        end
        check("timeout_no_res", q_res.size() - b_res, 0);
        check("timeout_done_count", n_done - b_done, 0);

        // Pass 3: restart clears the flag, then reset lands in POLL.
        p_stuck = 1'b0;
        start_pass(c0, k0, b_gw, b_res, b_done);
        check("restart_clears_error", error_o, 0);
        check("restart_busy", busy_o, 1);
        for (int i = 0; i < 100; i++) begin
            if (g_we_o && !g_select_o) break;
            @(negedge clk);
        end
        check("kick_seen", g_we_o && !g_select_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("poll_reset");
        rst = 1'b0;
        check("poll_reset_no_res", q_res.size() - b_res, 0);

        // Pass 4: clean run after reset.
        fill_image();
        start_pass(c0, k0, b_gw, b_res, b_done);
        wait_done(2000);
        @(negedge clk);
        check_pass(c0, k0, b_gw, b_res, b_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
